aether_cmd_frontend: RTL and testbench

Parametrised command front-end between the host command bus and the aether engine instruction port. It splits the packed host command into opcode, param_1 and param_2 fields and buffers commands in a FIFO. Commands are issued to the engine under a valid/ready handshake. It also adds behaviour the direct wiring lacks: NOP filtering, a FENCE opcode that waits for the engine to go idle, a sticky overflow flag and a maskable aggregated interrupt.

---
 rtl/aether_cmd_frontend.sv | 167 ++++++++++++++++
 tb/tb_aether_cmd_frontend.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/aether_cmd_frontend.sv
// aether_cmd_frontend
// Host command front-end for the aether engine instruction port.
//   - Host side : cmd_valid_i / cmd_i {opcode, param_1, param_2}, cmd_ready_o (FIFO not full)
//   - Engine    : instr_o / param_1_o / param_2_o with issue_valid_o / issue_ready_i
//   - Status    : engine_busy_i (FENCE barrier), engine_done_i (done event)
//   - IRQ       : irq_mask_i {overflow, fence, done}, irq_clear_i, registered interrupt_o
//   - Debug     : fifo_count_o, sticky overflow_o
// NOP opcodes are swallowed at the input. FENCE opcodes are consumed locally
// and hold the queue until the engine reports idle.
module aether_cmd_frontend #(
    parameter int InstrWidth  = 4,
    parameter int Param1Width = 4,
    parameter int Param2Width = 16,
    parameter int FifoDepth   = 8,
    parameter int NopOpcode   = 0,
    parameter int FenceOpcode = 15,
    localparam int CmdW = InstrWidth + Param1Width + Param2Width,
    localparam int CntW = $clog2(FifoDepth + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    input  logic [CmdW-1:0]        cmd_i,
    output logic                   cmd_ready_o,
    output logic [InstrWidth-1:0]  instr_o,
    output logic [Param1Width-1:0] param_1_o,
    output logic [Param2Width-1:0] param_2_o,
    output logic                   issue_valid_o,
    input  logic                   issue_ready_i,
    input  logic                   engine_busy_i,
    input  logic                   engine_done_i,
    input  logic [2:0]             irq_mask_i,
    input  logic                   irq_clear_i,
    output logic                   interrupt_o,
    output logic [CntW-1:0]        fifo_count_o,
    output logic                   overflow_o
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam logic [InstrWidth-1:0] NOP_OP   = InstrWidth'(NopOpcode);
    localparam logic [InstrWidth-1:0] FENCE_OP = InstrWidth'(FenceOpcode);
    localparam logic [CntW-1:0]       FULL_CNT = CntW'(FifoDepth);

    typedef enum logic [1:0] {IDLE, ISSUE, FENCE_WAIT} state_e;

    state_e          state_q, state_d;
    logic [CmdW-1:0] mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CmdW-1:0] issue_cmd_q, issue_cmd_d;
    logic            issue_valid_q, issue_valid_d;
    logic [2:0]      pending_q, pending_d;
    logic            overflow_q, overflow_d;
    logic            irq_q, irq_d;

    logic            full, empty, push, pop, drop, fence_retire, head_fence;
    logic [CmdW-1:0] head;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign head_fence = (head[CmdW-1 -: InstrWidth] == FENCE_OP);

    // Ready is a function of full only; a same-cycle pop never admits a write.
    assign push = cmd_valid_i & ~full & (cmd_i[CmdW-1 -: InstrWidth] != NOP_OP);
    assign drop = cmd_valid_i & full;

    // Issue sequencer. A handshake in ISSUE may reload from the head on the
    // same edge, giving one command per cycle while the engine keeps ready high.
    always_comb begin
        state_d       = state_q;
        issue_valid_d = issue_valid_q;
        issue_cmd_d   = issue_cmd_q;
        pop           = 1'b0;
        fence_retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_fence) begin
                        state_d = FENCE_WAIT;
                    end else begin
                        issue_valid_d = 1'b1;
                        issue_cmd_d   = head;
                        state_d       = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue_ready_i) begin
                    if (!empty) begin
                        pop = 1'b1;
                        if (head_fence) begin
                            issue_valid_d = 1'b0;
                            state_d       = FENCE_WAIT;
                        end else begin
                            issue_cmd_d = head;
                        end
                    end else begin
                        issue_valid_d = 1'b0;
                        state_d       = IDLE;
                    end
                end
            end
            FENCE_WAIT: begin
                if (!engine_busy_i) begin
                    fence_retire = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Clear first, then OR in sets so a coincident set survives the clear.
        pending_d  = (irq_clear_i ? 3'b000 : pending_q) | {drop, fence_retire, engine_done_i};
        overflow_d = (irq_clear_i ? 1'b0 : overflow_q) | drop;
        irq_d      = |(pending_q & irq_mask_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            issue_cmd_q   <= '0;
            issue_valid_q <= 1'b0;
            pending_q     <= '0;
            overflow_q    <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            issue_cmd_q   <= issue_cmd_d;
            issue_valid_q <= issue_valid_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            irq_q         <= irq_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= cmd_i;
    end

    assign cmd_ready_o   = ~full;
    assign instr_o       = issue_cmd_q[CmdW-1 -: InstrWidth];
    assign param_1_o     = issue_cmd_q[Param2Width +: Param1Width];
    assign param_2_o     = issue_cmd_q[Param2Width-1:0];
    assign issue_valid_o = issue_valid_q;
    assign interrupt_o   = irq_q;
    assign fifo_count_o  = count_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_aether_cmd_frontend.sv
// Directed bench for aether_cmd_frontend with hand-computed expectations.
module tb_aether_cmd_frontend;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic [23:0] cmd_i;
    logic        cmd_ready_o;
    logic [3:0]  instr_o;
    logic [3:0]  param_1_o;
    logic [15:0] param_2_o;
    logic        issue_valid_o;
    logic        issue_ready_i;
    logic        engine_busy_i;
    logic        engine_done_i;
    logic [2:0]  irq_mask_i;
    logic        irq_clear_i;
    logic        interrupt_o;
    logic [3:0]  fifo_count_o;
    logic        overflow_o;

    int checks   = 0;
    int failures = 0;
    logic fence_seen = 1'b0;

    aether_cmd_frontend dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i), .cmd_ready_o(cmd_ready_o),
        .instr_o(instr_o), .param_1_o(param_1_o), .param_2_o(param_2_o),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .engine_busy_i(engine_busy_i), .engine_done_i(engine_done_i),
        .irq_mask_i(irq_mask_i), .irq_clear_i(irq_clear_i),
        .interrupt_o(interrupt_o), .fifo_count_o(fifo_count_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // A FENCE must never be presented to the engine.
    always @(negedge clk_i) if (issue_valid_o && instr_o == 4'd15) fence_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [23:0] mk(input int op, input int p1, input int p2);
        return {4'(op), 4'(p1), 16'(p2)};
    endfunction

    initial begin
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_i = '0; issue_ready_i = 1'b0;
        engine_busy_i = 1'b0; engine_done_i = 1'b0; irq_mask_i = 3'b000; irq_clear_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_count", 32'(fifo_count_o), 0);
        chk("rst_ready", 32'(cmd_ready_o), 1);
        chk("rst_valid", 32'(issue_valid_o), 0);
        chk("rst_instr", 32'({instr_o, param_1_o, param_2_o}), 0);
        chk("rst_ovf",   32'(overflow_o), 0);
        chk("rst_irq",   32'(interrupt_o), 0);

        // Single command, latency and one-cycle presentation.
        issue_ready_i = 1'b1;
        cmd_valid_i = 1'b1; cmd_i = mk(1, 2, 16'h00AA);
        tick();
        cmd_valid_i = 1'b0;
        chk("t1_cnt1",   32'(fifo_count_o), 1);
        chk("t1_novld",  32'(issue_valid_o), 0);
        tick();
        chk("t1_vld",    32'(issue_valid_o), 1);
        chk("t1_fields", 32'({instr_o, param_1_o, param_2_o}), 32'(mk(1, 2, 16'h00AA)));
        chk("t1_cnt0",   32'(fifo_count_o), 0);
        tick();
        chk("t1_vldoff", 32'(issue_valid_o), 0);

        // Fill, overflow, then drain back-to-back.
        issue_ready_i = 1'b0; irq_mask_i = 3'b100;
        for (int i = 0; i < 9; i++) begin
            cmd_valid_i = 1'b1; cmd_i = mk(i + 1, i, 16'h0100 + i);
            tick();
        end
        chk("t2_full_cnt",   32'(fifo_count_o), 8);
        chk("t2_full_rdy",   32'(cmd_ready_o), 0);
        chk("t2_head_instr", 32'(instr_o), 1);
        cmd_i = mk(10, 0, 16'hDEAD);
        tick();
        cmd_valid_i = 1'b0;
        chk("t2_ovf",     32'(overflow_o), 1);
        chk("t2_ovf_cnt", 32'(fifo_count_o), 8);
        tick();
        chk("t2_irq",       32'(interrupt_o), 1);
        chk("t2_stall_vld", 32'(issue_valid_o), 1);
        chk("t2_stall_cmd", 32'({instr_o, param_1_o, param_2_o}), 32'(mk(1, 0, 16'h0100)));
        issue_ready_i = 1'b1;
        for (int j = 1; j < 9; j++) begin
            tick();
            chk("t2_b2b_vld", 32'(issue_valid_o), 1);
            chk("t2_b2b_cmd", 32'({instr_o, param_1_o, param_2_o}), 32'(mk(j + 1, j, 16'h0100 + j)));
        end
        chk("t2_drain_cnt", 32'(fifo_count_o), 0);
        tick();
        chk("t2_end_vld", 32'(issue_valid_o), 0);
        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
        chk("t2_ovf_clr", 32'(overflow_o), 0);
        tick();
        chk("t2_irq_clr", 32'(interrupt_o), 0);
        irq_mask_i = 3'b000;

        // NOP filtering.
        issue_ready_i = 1'b0;
        cmd_valid_i = 1'b1; cmd_i = mk(4, 1, 16'h4444);
        tick();
        cmd_i = mk(0, 3, 16'hFFFF);
        tick();
        chk("t3_nop_cnt", 32'(fifo_count_o), 0);
        chk("t3_cmd4",    32'(instr_o), 4);
        cmd_i = mk(5, 2, 16'h5555);
        tick();
        cmd_valid_i = 1'b0;
        chk("t3_cnt1", 32'(fifo_count_o), 1);
        issue_ready_i = 1'b1;
        tick();
        chk("t3_cmd5", 32'({instr_o, param_1_o, param_2_o}), 32'(mk(5, 2, 16'h5555)));
        tick();
        chk("t3_done", 32'({issue_valid_o, fifo_count_o}), 0);

        // FENCE barrier.
        engine_busy_i = 1'b1; irq_mask_i = 3'b010;
        cmd_valid_i = 1'b1; cmd_i = mk(15, 0, 0);
        tick();
        cmd_i = mk(3, 0, 16'h1234);
        tick();
        cmd_valid_i = 1'b0;
        tick(); tick(); tick();
        chk("t4_busy_vld", 32'(issue_valid_o), 0);
        chk("t4_busy_cnt", 32'(fifo_count_o), 1);
        chk("t4_busy_irq", 32'(interrupt_o), 0);
        engine_busy_i = 1'b0;
        tick();
        chk("t4_ret_vld", 32'(issue_valid_o), 0);
        tick();
        chk("t4_irq",   32'(interrupt_o), 1);
        chk("t4_vld",   32'(issue_valid_o), 1);
        chk("t4_cmd3",  32'({instr_o, param_1_o, param_2_o}), 32'(mk(3, 0, 16'h1234)));
        tick();
        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
        irq_mask_i = 3'b000;
        tick();

        // Set beats clear on the same edge.
        irq_mask_i = 3'b001;
        engine_done_i = 1'b1; irq_clear_i = 1'b1;
        tick();
        engine_done_i = 1'b0; irq_clear_i = 1'b0;
        tick();
        chk("t5_setwins", 32'(interrupt_o), 1);
        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
        tick();
        chk("t5_clr", 32'(interrupt_o), 0);
        irq_mask_i = 3'b000;

        // Reset mid-operation.
        issue_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid_i = 1'b1; cmd_i = mk(i + 1, 0, i);
            tick();
        end
        cmd_valid_i = 1'b0;
        chk("t6_pre_cnt", 32'(fifo_count_o), 5);
        chk("t6_pre_vld", 32'(issue_valid_o), 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t6_cnt",   32'(fifo_count_o), 0);
        chk("t6_vld",   32'(issue_valid_o), 0);
        chk("t6_ovf",   32'(overflow_o), 0);
        chk("t6_irq",   32'(interrupt_o), 0);
        chk("t6_ready", 32'(cmd_ready_o), 1);

        chk("no_fence_issued", 32'(fence_seen), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
